dram_init_sequencer: RTL and testbench

DRAM_INIT_SEQUENCER -- requirements
Module: dram_init_sequencer

---
 rtl/dram_init_sequencer_if.sv | 33 +++
 rtl/dram_init_sequencer.sv | 114 +++++++++++
 tb/tb_dram_init_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dram_init_sequencer_if.sv
// PHY command encoding and the sequencer's control/status bundle.
// master is the sequencer side, slave is the controller/PHY side.
package dram_init_pkg;
  typedef enum logic [2:0] {
    CMD_RESET    = 3'd0,
    CMD_POWER_UP = 3'd1,
    CMD_NOP      = 3'd2,
    CMD_MRS      = 3'd3,
    CMD_ZQCAL    = 3'd4
  } command_t;
endpackage

interface dram_init_if;
  import dram_init_pkg::*;

  logic       i_init_start;
  logic       i_reinit;
  command_t   o_command;
  logic [1:0] o_mode_register_num;
  logic       o_init_busy;
  logic       o_init_done;
  logic [3:0] o_state;

  modport master (
    input  i_init_start, i_reinit,
    output o_command, o_mode_register_num, o_init_busy, o_init_done, o_state
  );

  modport slave (
    output i_init_start, i_reinit,
    input  o_command, o_mode_register_num, o_init_busy, o_init_done, o_state
  );
endinterface

// File: rtl/dram_init_sequencer.sv
// DRAM power-up/initialisation sequencer: reset, CKE, MRS programming, ZQ cal.
// One shared down-counter times every state; all outputs come straight from flops.
//
// state | meaning
// IDLE  | waiting for i_init_start, DRAM held in reset
// RST   | DRAM reset asserted for T_RESET cycles
// CKE   | power-up with CKE low for T_CKE cycles
// XPR   | NOPs before the first MRS
// MR2   | MRS to MR2, then NOPs for T_MRD
// MR3   | MRS to MR3, then NOPs for T_MRD
// MR1   | MRS to MR1, then NOPs for T_MRD
// MR0   | MRS to MR0, then NOPs for T_MOD
// ZQ    | ZQCAL, then NOPs for T_ZQINIT
// DONE  | init complete, waiting for i_reinit
module dram_init_sequencer
  import dram_init_pkg::*;
#(
  parameter int unsigned T_RESET  = 16,
  parameter int unsigned T_CKE    = 32,
  parameter int unsigned T_XPR    = 8,
  parameter int unsigned T_MRD    = 4,
  parameter int unsigned T_MOD    = 12,
  parameter int unsigned T_ZQINIT = 64
) (
  input  logic         clk1,
  input  logic         rst_n,
  dram_init_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_RST = 4'd1, S_CKE = 4'd2, S_XPR = 4'd3, S_MR2 = 4'd4,
    S_MR3  = 4'd5, S_MR1 = 4'd6, S_MR0 = 4'd7, S_ZQ  = 4'd8, S_DONE = 4'd9
  } state_t;

  localparam logic [15:0] LD_RESET  = 16'(T_RESET - 1);
  localparam logic [15:0] LD_CKE    = 16'(T_CKE - 1);
  localparam logic [15:0] LD_XPR    = 16'(T_XPR - 1);
  localparam logic [15:0] LD_MRD    = 16'(T_MRD - 1);
  localparam logic [15:0] LD_MOD    = 16'(T_MOD - 1);
  localparam logic [15:0] LD_ZQINIT = 16'(T_ZQINIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  command_t    command_q, command_d;
  logic [1:0]  mr_num_q, mr_num_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        expired;
  logic        entering;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      command_q <= CMD_RESET;
      mr_num_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      command_q <= command_d;
      mr_num_q  <= mr_num_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    command_d = CMD_NOP;
    mr_num_d  = mr_num_q;
    expired   = (cnt_q == 16'd0);

    case (state_q)
      S_IDLE: if (bus.i_init_start) begin state_d = S_RST; cnt_d = LD_RESET; end
      S_RST:  if (expired) begin state_d = S_CKE; cnt_d = LD_CKE;    end else cnt_d = cnt_q - 16'd1;
      S_CKE:  if (expired) begin state_d = S_XPR; cnt_d = LD_XPR;    end else cnt_d = cnt_q - 16'd1;
      S_XPR:  if (expired) begin state_d = S_MR2; cnt_d = LD_MRD;    end else cnt_d = cnt_q - 16'd1;
      S_MR2:  if (expired) begin state_d = S_MR3; cnt_d = LD_MRD;    end else cnt_d = cnt_q - 16'd1;
      S_MR3:  if (expired) begin state_d = S_MR1; cnt_d = LD_MRD;    end else cnt_d = cnt_q - 16'd1;
      S_MR1:  if (expired) begin state_d = S_MR0; cnt_d = LD_MOD;    end else cnt_d = cnt_q - 16'd1;
      S_MR0:  if (expired) begin state_d = S_ZQ;  cnt_d = LD_ZQINIT; end else cnt_d = cnt_q - 16'd1;
      S_ZQ:   if (expired) begin state_d = S_DONE; cnt_d = '0;       end else cnt_d = cnt_q - 16'd1;
      S_DONE: if (bus.i_reinit) begin state_d = S_RST; cnt_d = LD_RESET; end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase

    // Outputs are decoded from the next state so the flops line up with state_q.
    // No state loops to itself, so a state change marks its first cycle.
    entering = (state_d != state_q);
    case (state_d)
      S_IDLE, S_RST: command_d = CMD_RESET;
      S_CKE:         command_d = CMD_POWER_UP;
      S_MR2: if (entering) begin command_d = CMD_MRS; mr_num_d = 2'd2; end
      S_MR3: if (entering) begin command_d = CMD_MRS; mr_num_d = 2'd3; end
      S_MR1: if (entering) begin command_d = CMD_MRS; mr_num_d = 2'd1; end
      S_MR0: if (entering) begin command_d = CMD_MRS; mr_num_d = 2'd0; end
      S_ZQ:  if (entering) command_d = CMD_ZQCAL;
      default: command_d = CMD_NOP;
    endcase

    busy_d = !(state_d inside {S_IDLE, S_DONE});
    done_d = (state_d == S_DONE);
  end

  assign bus.o_command           = command_q;
  assign bus.o_mode_register_num = mr_num_q;
  assign bus.o_init_busy         = busy_q;
  assign bus.o_init_done         = done_q;
  assign bus.o_state             = state_q;

endmodule

// File: tb/tb_dram_init_sequencer.sv
// Directed bench: default-timing DUT walked cycle by cycle against a hand table,
// plus reinit, mid-sequence reset abort and an all-ones timing DUT.
module tb_dram_init_sequencer;
  import dram_init_pkg::*;

  logic clk1;
  logic rst_n;
  int   checks;
  int   errors;

  dram_init_if ifa ();
  dram_init_if ifb ();

  dram_init_sequencer dut_a (.clk1(clk1), .rst_n(rst_n), .bus(ifa));

  dram_init_sequencer #(
    .T_RESET(1), .T_CKE(1), .T_XPR(1), .T_MRD(1), .T_MOD(1), .T_ZQINIT(1)
  ) dut_b (.clk1(clk1), .rst_n(rst_n), .bus(ifb));

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected command at cycle c counted from RST entry, default timing.
  function automatic command_t exp_cmd(input int c);
    if (c < 16) return CMD_RESET;
    if (c < 48) return CMD_POWER_UP;
    if (c == 56 || c == 60 || c == 64 || c == 68) return CMD_MRS;
    if (c == 80) return CMD_ZQCAL;
    return CMD_NOP;
  endfunction

  function automatic logic [1:0] exp_mr(input int c);
    if (c < 56) return 2'd0;
    if (c < 60) return 2'd2;
    if (c < 64) return 2'd3;
    if (c < 68) return 2'd1;
    return 2'd0;
  endfunction

  command_t   t1_cmd [9];
  logic [1:0] t1_mr  [9];

  initial begin
    int n;
    int mrs_cnt;
    int zq_cnt;

    checks = 0;
    errors = 0;
    mrs_cnt = 0;
    zq_cnt = 0;
    t1_cmd = '{CMD_RESET, CMD_POWER_UP, CMD_NOP, CMD_MRS, CMD_MRS, CMD_MRS, CMD_MRS, CMD_ZQCAL, CMD_NOP};
    t1_mr  = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};

    rst_n = 1'b0;
    ifa.i_init_start = 1'b0;
    ifa.i_reinit = 1'b0;
    ifb.i_init_start = 1'b0;
    ifb.i_reinit = 1'b0;
    repeat (3) step();

    chk("rst_state", ifa.o_state, 16'd0);
    chk("rst_cmd", ifa.o_command, CMD_RESET);
    chk("rst_mr", ifa.o_mode_register_num, 16'd0);
    chk("rst_busy", ifa.o_init_busy, 16'd0);
    chk("rst_done", ifa.o_init_done, 16'd0);

    @(negedge clk1);
    rst_n = 1'b1;
    step();
    chk("idle_state", ifa.o_state, 16'd0);
    chk("idle_cmd", ifa.o_command, CMD_RESET);

    // Start one cycle after reset release; drop it early and poke reinit in XPR.
    ifa.i_init_start = 1'b1;
    step();
    for (int c = 0; c < 144; c++) begin
      chk($sformatf("cmd_c%0d", c), ifa.o_command, exp_cmd(c));
      chk($sformatf("mr_c%0d", c), ifa.o_mode_register_num, exp_mr(c));
      chk($sformatf("busy_c%0d", c), ifa.o_init_busy, 16'd1);
      chk($sformatf("done_c%0d", c), ifa.o_init_done, 16'd0);
      if (ifa.o_command == CMD_MRS) mrs_cnt++;
      if (ifa.o_command == CMD_ZQCAL) zq_cnt++;
      if (c == 5) ifa.i_init_start = 1'b0;
      if (c == 50) ifa.i_reinit = 1'b1;
      if (c == 51) ifa.i_reinit = 1'b0;
      step();
    end
    chk("mrs_count", 16'(mrs_cnt), 16'd4);
    chk("zq_count", 16'(zq_cnt), 16'd1);
    chk("done_at144", ifa.o_init_done, 16'd1);
    chk("busy_at144", ifa.o_init_busy, 16'd0);
    chk("cmd_at144", ifa.o_command, CMD_NOP);
    chk("state_at144", ifa.o_state, 16'd9);
    chk("mr_hold_done", ifa.o_mode_register_num, 16'd0);

    repeat (5) step();
    chk("done_hold", ifa.o_init_done, 16'd1);
    chk("state_hold", ifa.o_state, 16'd9);

    // Reinit from DONE.
    ifa.i_reinit = 1'b1;
    step();
    ifa.i_reinit = 1'b0;
    chk("reinit_state", ifa.o_state, 16'd1);
    chk("reinit_done", ifa.o_init_done, 16'd0);
    chk("reinit_busy", ifa.o_init_busy, 16'd1);
    chk("reinit_cmd", ifa.o_command, CMD_RESET);
    n = 0;
    while (!ifa.o_init_done && n < 1000) begin
      step();
      n++;
    end
    chk("reinit_len", 16'(n), 16'd144);

    // Abort mid-MR3 with an asynchronous reset.
    ifa.i_reinit = 1'b1;
    step();
    ifa.i_reinit = 1'b0;
    repeat (60) step();
    chk("pre_abort_state", ifa.o_state, 16'd5);
    chk("pre_abort_cmd", ifa.o_command, CMD_MRS);
    chk("pre_abort_mr", ifa.o_mode_register_num, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", ifa.o_state, 16'd0);
    chk("abort_cmd", ifa.o_command, CMD_RESET);
    chk("abort_mr", ifa.o_mode_register_num, 16'd0);
    chk("abort_busy", ifa.o_init_busy, 16'd0);
    chk("abort_done", ifa.o_init_done, 16'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (4) step();
    chk("post_abort_state", ifa.o_state, 16'd0);
    chk("post_abort_cmd", ifa.o_command, CMD_RESET);

    ifa.i_init_start = 1'b1;
    step();
    ifa.i_init_start = 1'b0;
    chk("restart_state", ifa.o_state, 16'd1);
    n = 0;
    while (!ifa.o_init_done && n < 1000) begin
      step();
      n++;
    end
    chk("restart_len", 16'(n), 16'd144);

    // All timing parameters at 1: one cycle per state.
    ifb.i_init_start = 1'b1;
    step();
    ifb.i_init_start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("t1_cmd_c%0d", c), ifb.o_command, t1_cmd[c]);
      chk($sformatf("t1_state_c%0d", c), ifb.o_state, 16'(c + 1));
      chk($sformatf("t1_done_c%0d", c), ifb.o_init_done, (c == 8) ? 16'd1 : 16'd0);
      if (t1_cmd[c] == CMD_MRS)
        chk($sformatf("t1_mr_c%0d", c), ifb.o_mode_register_num, t1_mr[c]);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
